// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory with valid/ready request/response and fixed latency.
// Define DATA_MEM_ERR_EN to flag out-of-range accesses on rsp_err.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096,
  parameter int LATENCY    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  accept, in_range;
  logic [IW-1:0]         idx;
  assign accept    = state_q == IDLE && req_valid;
  assign in_range  = {1'b0, req_addr} < (ADDR_WIDTH+1)'(DEPTH);
  assign idx       = req_addr[IW-1:0];
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rdata_d   = accept ? (!req_we && in_range ? mem[idx] : '0) : rdata_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = LATENCY == 1 ? RESP : BUSY;
        cnt_d   = 4'(LATENCY - 1);
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end
  // Array has no reset; stores commit on the accept edge so a following load sees them.
  always_ff @(posedge clk) begin
    if (accept && req_we && in_range)
      for (int b = 0; b < DATA_WIDTH/8; b++)
        if (req_wstrb[b]) mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
  end
`ifdef DATA_MEM_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (accept) err_q <= !in_range;
  end
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks of two responder configurations against a memory model.
module tb_data_mem_responder;
`ifdef DATA_MEM_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  int LAT [2] = '{1, 4};
  int DEP [2] = '{4096, 3000};
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid [2], req_ready [2], req_we [2], rsp_valid [2], rsp_ready [2], rsp_err [2];
  logic [11:0] req_addr [2];
  logic [31:0] req_wdata [2], rsp_rdata [2];
  logic [3:0]  req_wstrb [2];
  logic [31:0] mdl [2][4096];
  logic [31:0] exp_rdata [2], last_rdata [2];
  logic        exp_err [2], last_err [2];
  int          n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : u
    data_mem_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(g == 0 ? 4096 : 3000),
                         .LATENCY(g == 0 ? 1 : 4)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_we(req_we[g]), .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .req_wstrb(req_wstrb[g]), .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]));
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic send(input int k, input bit we, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    bit inr;
    inr = int'(a) < DEP[k];
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready[k]), 1);
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = a; req_wdata[k] = d; req_wstrb[k] = s;
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0; req_we[k] = 1'($urandom); req_addr[k] = 12'($urandom);
    req_wdata[k] = $urandom; req_wstrb[k] = 4'($urandom);
    if (we) begin
      if (inr) for (int b = 0; b < 4; b++) if (s[b]) mdl[k][a][8*b +: 8] = d[8*b +: 8];
      exp_rdata[k] = '0;
    end else exp_rdata[k] = inr ? mdl[k][a] : '0;
    exp_err[k] = ERR && !inr;
  endtask
  task automatic recv(input int k, input int hold);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!rsp_valid[k]) chk("busy_req_ready", 32'(req_ready[k]), 0);
    end while (!rsp_valid[k] && lat < 20);
    chk("latency", lat, LAT[k]);
    last_rdata[k] = rsp_rdata[k];
    last_err[k]   = rsp_err[k];
    chk("rdata", rsp_rdata[k], exp_rdata[k]);
    chk("err", 32'(rsp_err[k]), 32'(exp_err[k]));
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid[k]), 1);
      chk("hold_rdata", rsp_rdata[k], last_rdata[k]);
      chk("hold_err", 32'(rsp_err[k]), 32'(last_err[k]));
      chk("hold_req_ready", 32'(req_ready[k]), 0);
    end
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[k] = 1'b0;
    chk("post_req_ready", 32'(req_ready[k]), 1);
    chk("post_rsp_valid", 32'(rsp_valid[k]), 0);
  endtask
  initial begin
    logic [11:0] a;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 0; req_we[k] = 0; req_addr[k] = 0; req_wdata[k] = 0; req_wstrb[k] = 0; rsp_ready[k] = 0;
    end
    #12;
    for (int k = 0; k < 2; k++) begin
      chk("rst_req_ready", 32'(req_ready[k]), 1);
      chk("rst_rsp_valid", 32'(rsp_valid[k]), 0);
      chk("rst_rdata", rsp_rdata[k], 0);
      chk("rst_err", 32'(rsp_err[k]), 0);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) begin
        a = i < 16 ? 12'(i) : 12'(12'hBB0 + i - 16);
        if (int'(a) < DEP[k]) begin send(k, 1, a, $urandom, 4'hF); recv(k, 0); end
      end
    send(0, 1, 12'h010, 32'hDEADBEEF, 4'hF); recv(0, 0);
    send(0, 0, 12'h010, 32'h0, 4'h0); recv(0, 0);
    chk("raw_load", last_rdata[0], 32'hDEADBEEF);
    chk("raw_err", 32'(last_err[0]), 0);
    send(0, 1, 12'h020, 32'h11223344, 4'hF); recv(0, 0);
    send(0, 1, 12'h020, 32'hAABBCCDD, 4'b0101); recv(0, 0);
    send(0, 0, 12'h020, 32'h0, 4'h0); recv(0, 0);
    chk("strobe_merge", last_rdata[0], 32'h11BB33DD);
    send(0, 1, 12'h020, 32'h55555555, 4'h0); recv(0, 0);
    send(0, 0, 12'h020, 32'h0, 4'h0); recv(0, 0);
    chk("zero_strobe", last_rdata[0], 32'h11BB33DD);
    send(1, 1, 12'h007, 32'h0BADF00D, 4'hF); recv(1, 0);
    send(1, 0, 12'h007, 32'h0, 4'h0); recv(1, 5);
    chk("lat4_load", last_rdata[1], 32'h0BADF00D);
    send(1, 1, 12'hBB8, 32'h12345678, 4'hF); recv(1, 0);
    chk("oor_store_err", 32'(last_err[1]), 32'(ERR));
    send(1, 0, 12'hBB8, 32'h0, 4'h0); recv(1, 0);
    chk("oor_load_data", last_rdata[1], 0);
    chk("oor_load_err", 32'(last_err[1]), 32'(ERR));
    send(1, 1, 12'hBB7, 32'h76543210, 4'hF); recv(1, 0);
    send(1, 0, 12'hBB7, 32'h0, 4'h0); recv(1, 0);
    chk("edge_load", last_rdata[1], 32'h76543210);
    chk("edge_err", 32'(last_err[1]), 0);
    send(1, 1, 12'h005, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(rsp_valid[1]), 0);
    chk("midrst_ready", 32'(req_ready[1]), 1);
    @(negedge clk) rst_n = 1'b1;
    send(1, 0, 12'h005, 32'h0, 4'h0); recv(1, 0);
    chk("midrst_commit", last_rdata[1], 32'hCAFEF00D);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 150; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          chk("idle_no_rsp", 32'(rsp_valid[k]), 0);
        end
        a = $urandom_range(0, 1) ? 12'($urandom_range(0, 15)) : 12'(12'hBB0 + $urandom_range(0, 15));
        send(k, 1'($urandom), a, $urandom, 4'($urandom));
        recv(k, $urandom_range(0, 3));
      end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
